e_mdu: RTL and testbench
========================

// Module: e_mdu
// PURPOSE
//  Execute-stage multiply/divide unit; consumes the D->E pipeline register outputs (RS_E, RT_E, decoded IR_E op).
//  Holds the architectural HI/LO registers and runs a multi-cycle mult/div sequence with a Busy flag.
//  The hazard unit stalls D on Busy|Start. HI/LO are read back through the E-stage result mux (mfhi/mflo).
// PARAMETERS
//  MULT_CYC  5   Busy cycles for MULT/MULTU (and MADD when enabled); legal range 1..15
//  DIV_CYC   10  Busy cycles for DIV/DIVU; legal range 1..15
// PORTS
//  clk      in   1   clock, all state on posedge
//  reset    in   1   asynchronous, active-low reset (0 = reset)
//  Start    in   1   one-cycle request; MDOp and operands are valid this cycle
//  MDOp     in   3   000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 MADD
//  RS_E     in   32  operand A (rs), already forwarded
//  RT_E     in   32  operand B (rt), already forwarded
//  Cancel   in   1   the E-stage instruction is being flushed (exception/interrupt in M); suppresses Start this cycle
//  Busy     out  1   registered; 1 while a mult/div sequence is in flight
//  HI       out  32  architectural HI
//  LO       out  32  architectural LO
// BEHAVIOUR
//  - Reset (reset==0, async): Busy=0, HI=0, LO=0, counter=0, latched operands=0, pending op=none.
//  - Accept: the op is accepted at a posedge where Start=1, Cancel=0 and Busy=0. Otherwise the request is dropped with no state change.
//    - Start while Busy is illegal. It is ignored, and the in-flight op is unaffected.
//  - MULT/MULTU/DIV/DIVU accept: latch RS_E, RT_E and the op. Load counter=N (MULT_CYC or DIV_CYC). Busy=1 from the next cycle.
//  - Each posedge with Busy=1: counter decrements. At the edge where counter goes 1->0, write HI/LO and clear Busy at the same edge.
//    - HI/LO are valid the cycle Busy is first 0.
//    - Total: Start in cycle k gives Busy=1 in cycles k+1..k+N, and the new HI/LO are visible in cycle k+N+1.
//  - MULT: {HI,LO} = signed(A)*signed(B), 64-bit. MULTU: the same product, unsigned.
//  - DIV: LO = signed quotient truncated toward zero; HI = remainder with the sign of the dividend.
//    - DIVU: unsigned quotient and remainder.
//    - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
//  - Divide by zero (B==0): the full DIV_CYC Busy sequence runs, then HI/LO are left unchanged.
//  - MTHI/MTLO: single-cycle. At the accepting edge HI<=RS_E (or LO<=RS_E); Busy stays 0.
//  - MDOp=000 with Start=1: no effect.
//  - Cancel has no effect on an in-flight op: once accepted, an op always completes. The hazard unit never issues a cancellable op while Busy.
//  - Async reset mid-sequence: the op is abandoned immediately, all state returns to its reset value, and Busy=0 without waiting for a clock.
//  - HI/LO change only at completion edges, MTHI/MTLO edges, or reset.
// CONFIGURATION
//  - Macro MDU_MADD_EN defined:
//    - MDOp=111 (MADD) is accepted like MULT with MULT_CYC latency.
//    - HI and LO are sampled at completion, not at accept: {HI,LO} <= {HI,LO} + signed(A)*signed(B), mod 2^64.
//  - Macro MDU_MADD_EN undefined: MDOp=111 is treated as none. It is never accepted, Busy stays 0, and HI/LO are unchanged.
// TESTING
//  1. Reset release, then MULT A=0xFFFFFFFE(-2), B=3 -> Busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
//  2. MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> after 5 Busy cycles HI=0xFFFFFFFE, LO=0x00000001.
//  3. DIV A=-7(0xFFFFFFF9), B=2 -> Busy 10 cycles; LO=0xFFFFFFFD(-3), HI=0xFFFFFFFF(-1).
//     DIVU 7/0 with HI=0x11, LO=0x22 preloaded -> Busy 10 cycles; HI/LO stay 0x11/0x22.
//  4. MTHI 0x1234 then MTLO 0x5678 on back-to-back cycles -> Busy never rises; HI=0x1234, LO=0x5678 one edge after each.
//     Start+MULT with Cancel=1 -> Busy stays 0; HI/LO unchanged.
//  5. DIV started; second Start (MULT) in Busy cycle 3 -> ignored; the DIV result lands at cycle k+11.
//     reset=0 pulsed in Busy cycle 4 (between edges) -> Busy, HI and LO go to 0 immediately.
//  6. (MDU_MADD_EN) HI=0, LO=0xFFFFFFFF, MADD 1*1 -> HI=1, LO=0 after 5 Busy cycles.
//     Without the macro, the same stimulus leaves Busy=0 and HI/LO unchanged.

Source files
------------

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit: architectural HI/LO plus a counted multi-cycle mult/div sequence.
// Optional MADD accumulate support is compiled in with `define MDU_MADD_EN.
module e_mdu #(
   parameter int MULT_CYC = 5,
   parameter int DIV_CYC  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        Start,
   input  logic [2:0]  MDOp,
   input  logic [31:0] RS_E,
   input  logic [31:0] RT_E,
   input  logic        Cancel,
   output logic        Busy,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   typedef enum logic [2:0] {
      OP_NONE  = 3'd0, OP_MULT = 3'd1, OP_MULTU = 3'd2, OP_DIV  = 3'd3,
      OP_DIVU  = 3'd4, OP_MTHI = 3'd5, OP_MTLO  = 3'd6, OP_MADD = 3'd7
   } md_op_e;

   typedef enum logic {S_IDLE, S_RUN} state_e;

   typedef struct packed {
      md_op_e      op;
      logic [31:0] a;
      logic [31:0] b;
   } md_req_t;

   state_e      state, state_nxt;
   md_req_t     req, req_nxt;
   logic [3:0]  cnt, cnt_nxt;
   logic [31:0] hi_nxt, lo_nxt;

   logic        accept, is_mul, is_div;
   logic        m_sgn, d_sgn, a_neg, b_neg;
   logic [63:0] ext_a, ext_b, prod;
   logic [31:0] ua, ub, q_mag, r_mag, quo, rem;

   assign Busy   = (state == S_RUN);
   assign accept = Start & ~Cancel & (state == S_IDLE);

   always_comb begin
      is_div = (MDOp == OP_DIV) || (MDOp == OP_DIVU);
      is_mul = (MDOp == OP_MULT) || (MDOp == OP_MULTU);
`ifdef MDU_MADD_EN
      if (MDOp == OP_MADD) is_mul = 1'b1;
`endif
   end

   // Multiplier: sign-extend to 64 bits so one truncated product serves signed and unsigned.
   always_comb begin
      m_sgn = (req.op != OP_MULTU);
      ext_a = m_sgn ? {{32{req.a[31]}}, req.a} : {32'b0, req.a};
      ext_b = m_sgn ? {{32{req.b[31]}}, req.b} : {32'b0, req.b};
      prod  = ext_a * ext_b;
   end

   // Divider works on magnitudes; this also yields 0x80000000/-1 = 0x80000000 rem 0 without overflow.
   always_comb begin
      d_sgn = (req.op == OP_DIV);
      a_neg = d_sgn & req.a[31];
      b_neg = d_sgn & req.b[31];
      ua    = a_neg ? -req.a : req.a;
      ub    = b_neg ? -req.b : req.b;
      q_mag = (ub == 32'd0) ? 32'd0 : ua / ub;
      r_mag = (ub == 32'd0) ? 32'd0 : ua % ub;
      quo   = (a_neg ^ b_neg) ? -q_mag : q_mag;
      rem   = a_neg ? -r_mag : r_mag;
   end

   always_comb begin
      state_nxt = state;
      req_nxt   = req;
      cnt_nxt   = cnt;
      hi_nxt    = HI;
      lo_nxt    = LO;
      case (state)
         S_IDLE: begin
            if (accept) begin
               if (is_mul || is_div) begin
                  req_nxt   = '{op: md_op_e'(MDOp), a: RS_E, b: RT_E};
                  cnt_nxt   = is_div ? 4'(DIV_CYC) : 4'(MULT_CYC);
                  state_nxt = S_RUN;
               end else if (MDOp == OP_MTHI) begin
                  hi_nxt = RS_E;
               end else if (MDOp == OP_MTLO) begin
                  lo_nxt = RS_E;
               end
            end
         end
         S_RUN: begin
            cnt_nxt = cnt - 4'd1;
            if (cnt == 4'd1) begin
               state_nxt = S_IDLE;
               case (req.op)
                  OP_MULT, OP_MULTU: {hi_nxt, lo_nxt} = prod;
`ifdef MDU_MADD_EN
                  OP_MADD:           {hi_nxt, lo_nxt} = {HI, LO} + prod;
`endif
                  OP_DIV, OP_DIVU: begin
                     // divide by zero leaves HI/LO untouched after the full sequence
                     if (req.b != 32'd0) begin
                        hi_nxt = rem;
                        lo_nxt = quo;
                     end
                  end
                  default: ;
               endcase
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
         req   <= '0;
         cnt   <= '0;
         HI    <= '0;
         LO    <= '0;
      end else begin
         state <= state_nxt;
         req   <= req_nxt;
         cnt   <= cnt_nxt;
         HI    <= hi_nxt;
         LO    <= lo_nxt;
      end
   end

endmodule

// File: tb/tb_e_mdu.sv
// Bench for e_mdu: directed scenarios plus randomized ops against an arithmetic HI/LO model.
module tb_e_mdu;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        Start = 1'b0;
   logic        Cancel = 1'b0;
   logic [2:0]  MDOp = 3'd0;
   logic [31:0] RS_E = 32'd0;
   logic [31:0] RT_E = 32'd0;
   logic        Busy;
   logic [31:0] HI, LO;

   int          errors = 0;
   int          checks = 0;
   logic [31:0] m_hi = 32'd0;
   logic [31:0] m_lo = 32'd0;

   e_mdu #(.MULT_CYC(5), .DIV_CYC(10)) dut (
      .clk(clk), .reset(reset), .Start(Start), .MDOp(MDOp), .RS_E(RS_E),
      .RT_E(RT_E), .Cancel(Cancel), .Busy(Busy), .HI(HI), .LO(LO)
   );

   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference: architectural effect of one accepted op and its expected Busy length.
   task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int cyc);
      longint      sa, sb;
      logic [63:0] p;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      cyc = 0;
      case (op)
         3'd1: begin p = 64'(sa * sb); {m_hi, m_lo} = p; cyc = 5; end
         3'd2: begin p = {32'b0, a} * {32'b0, b}; {m_hi, m_lo} = p; cyc = 5; end
         3'd3: begin
            cyc = 10;
            if (b != 0) begin m_lo = 32'(sa / sb); m_hi = 32'(sa % sb); end
         end
         3'd4: begin
            cyc = 10;
            if (b != 0) begin m_lo = a / b; m_hi = a % b; end
         end
         3'd5: m_hi = a;
         3'd6: m_lo = a;
         3'd7: begin
`ifdef MDU_MADD_EN
            p = {m_hi, m_lo} + 64'(sa * sb);
            {m_hi, m_lo} = p;
            cyc = 5;
`endif
         end
         default: ;
      endcase
   endtask

   // Present a one-cycle request; returns at the negedge after the accepting posedge.
   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic c);
      @(negedge clk);
      Start = 1'b1; MDOp = op; RS_E = a; RT_E = b; Cancel = c;
      @(negedge clk);
      Start = 1'b0; MDOp = 3'd0; Cancel = 1'b0;
   endtask

   task automatic count_busy(output int n);
      n = 0;
      while (Busy === 1'b1 && n < 40) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", Busy); end
      checks++; if (HI !== 32'd0) begin errors++; $display("FAIL reset_hi: got %h want 0", HI); end
      checks++; if (LO !== 32'd0) begin errors++; $display("FAIL reset_lo: got %h want 0", LO); end
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_mult();
      int cyc, n;
      model(3'd1, 32'hFFFFFFFE, 32'd3, cyc);
      issue(3'd1, 32'hFFFFFFFE, 32'd3, 1'b0);
      count_busy(n);
      checks++; if (n !== 5) begin errors++; $display("FAIL mult_busy: got %0d want 5", n); end
      checks++; if (HI !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi: got %h want ffffffff", HI); end
      checks++; if (LO !== 32'hFFFFFFFA) begin errors++; $display("FAIL mult_lo: got %h want fffffffa", LO); end
      model(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, cyc);
      issue(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
      count_busy(n);
      checks++; if (n !== 5) begin errors++; $display("FAIL multu_busy: got %0d want 5", n); end
      checks++; if (HI !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_hi: got %h want fffffffe", HI); end
      checks++; if (LO !== 32'h00000001) begin errors++; $display("FAIL multu_lo: got %h want 00000001", LO); end
   endtask

   task automatic test_div();
      int cyc, n;
      model(3'd3, 32'hFFFFFFF9, 32'd2, cyc);
      issue(3'd3, 32'hFFFFFFF9, 32'd2, 1'b0);
      count_busy(n);
      checks++; if (n !== 10) begin errors++; $display("FAIL div_busy: got %0d want 10", n); end
      checks++; if (LO !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_lo: got %h want fffffffd", LO); end
      checks++; if (HI !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_hi: got %h want ffffffff", HI); end
      model(3'd3, 32'h80000000, 32'hFFFFFFFF, cyc);
      issue(3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0);
      count_busy(n);
      checks++; if (LO !== 32'h80000000) begin errors++; $display("FAIL div_ovf_lo: got %h want 80000000", LO); end
      checks++; if (HI !== 32'h0) begin errors++; $display("FAIL div_ovf_hi: got %h want 0", HI); end
      model(3'd5, 32'h11, 32'd0, cyc); issue(3'd5, 32'h11, 32'd0, 1'b0);
      model(3'd6, 32'h22, 32'd0, cyc); issue(3'd6, 32'h22, 32'd0, 1'b0);
      model(3'd4, 32'd7, 32'd0, cyc);
      issue(3'd4, 32'd7, 32'd0, 1'b0);
      count_busy(n);
      checks++; if (n !== 10) begin errors++; $display("FAIL divz_busy: got %0d want 10", n); end
      checks++; if (HI !== 32'h11) begin errors++; $display("FAIL divz_hi: got %h want 11", HI); end
      checks++; if (LO !== 32'h22) begin errors++; $display("FAIL divz_lo: got %h want 22", LO); end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      Start = 1'b1; MDOp = 3'd5; RS_E = 32'h1234;
      @(negedge clk);
      checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL mthi_busy: got %b want 0", Busy); end
      checks++; if (HI !== 32'h1234) begin errors++; $display("FAIL mthi_hi: got %h want 1234", HI); end
      MDOp = 3'd6; RS_E = 32'h5678;
      @(negedge clk);
      Start = 1'b0; MDOp = 3'd0;
      checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL mtlo_busy: got %b want 0", Busy); end
      checks++; if (LO !== 32'h5678) begin errors++; $display("FAIL mtlo_lo: got %h want 5678", LO); end
      checks++; if (HI !== 32'h1234) begin errors++; $display("FAIL mtlo_hi: got %h want 1234", HI); end
      m_hi = 32'h1234; m_lo = 32'h5678;
   endtask

   task automatic test_cancel();
      issue(3'd1, 32'd5, 32'd6, 1'b1);
      checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL cancel_busy: got %b want 0", Busy); end
      issue(3'd0, 32'd9, 32'd9, 1'b0);
      checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL none_busy: got %b want 0", Busy); end
      checks++; if (HI !== m_hi) begin errors++; $display("FAIL cancel_hi: got %h want %h", HI, m_hi); end
      checks++; if (LO !== m_lo) begin errors++; $display("FAIL cancel_lo: got %h want %h", LO, m_lo); end
   endtask

   task automatic test_start_while_busy();
      int cyc, tot;
      model(3'd3, 32'd100, 32'd7, cyc);
      issue(3'd3, 32'd100, 32'd7, 1'b0);
      tot = 0;
      while (Busy === 1'b1 && tot < 40) begin
         tot++;
         if (tot == 3) begin Start = 1'b1; MDOp = 3'd1; RS_E = 32'd3; RT_E = 32'd4; end
         else begin Start = 1'b0; MDOp = 3'd0; end
         @(negedge clk);
      end
      Start = 1'b0; MDOp = 3'd0;
      checks++; if (tot !== 10) begin errors++; $display("FAIL sbusy_len: got %0d want 10", tot); end
      checks++; if (LO !== 32'd14) begin errors++; $display("FAIL sbusy_lo: got %h want e", LO); end
      checks++; if (HI !== 32'd2) begin errors++; $display("FAIL sbusy_hi: got %h want 2", HI); end
      @(negedge clk);
      checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL sbusy_after: got %b want 0", Busy); end
   endtask

   task automatic test_async_reset();
      int n;
      issue(3'd3, 32'd1000, 32'd3, 1'b0);
      repeat (3) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL arst_busy: got %b want 0", Busy); end
      checks++; if (HI !== 32'd0) begin errors++; $display("FAIL arst_hi: got %h want 0", HI); end
      checks++; if (LO !== 32'd0) begin errors++; $display("FAIL arst_lo: got %h want 0", LO); end
      @(negedge clk);
      reset = 1'b1;
      m_hi = 32'd0; m_lo = 32'd0;
      count_busy(n);
      repeat (12) @(negedge clk);
      checks++; if (Busy !== 1'b0 || n !== 0) begin errors++; $display("FAIL arst_idle: got busy=%b n=%0d want 0", Busy, n); end
      checks++; if (LO !== 32'd0) begin errors++; $display("FAIL arst_lo_hold: got %h want 0", LO); end
   endtask

   task automatic test_madd();
      int cyc, n;
      model(3'd5, 32'd0, 32'd0, cyc); issue(3'd5, 32'd0, 32'd0, 1'b0);
      model(3'd6, 32'hFFFFFFFF, 32'd0, cyc); issue(3'd6, 32'hFFFFFFFF, 32'd0, 1'b0);
      model(3'd7, 32'd1, 32'd1, cyc);
      issue(3'd7, 32'd1, 32'd1, 1'b0);
      count_busy(n);
      checks++; if (n !== cyc) begin errors++; $display("FAIL madd_busy: got %0d want %0d", n, cyc); end
      checks++; if (HI !== m_hi) begin errors++; $display("FAIL madd_hi: got %h want %h", HI, m_hi); end
      checks++; if (LO !== m_lo) begin errors++; $display("FAIL madd_lo: got %h want %h", LO, m_lo); end
   endtask

   task automatic test_random();
      int cyc, n;
      logic [2:0]  op;
      logic [31:0] a, b;
      for (int i = 0; i < 40; i++) begin
         op = 3'($urandom_range(1, 7));
         a  = $urandom;
         b  = ($urandom_range(0, 7) == 0) ? 32'd0 :
              ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 300)) : $urandom;
         if ($urandom_range(0, 3) == 0) a = 32'h80000000 | 32'($urandom_range(0, 3));
         model(op, a, b, cyc);
         issue(op, a, b, 1'b0);
         count_busy(n);
         checks++; if (n !== cyc) begin errors++; $display("FAIL rnd_busy[%0d] op=%0d: got %0d want %0d", i, op, n, cyc); end
         checks++; if (HI !== m_hi) begin errors++; $display("FAIL rnd_hi[%0d] op=%0d a=%h b=%h: got %h want %h", i, op, a, b, HI, m_hi); end
         checks++; if (LO !== m_lo) begin errors++; $display("FAIL rnd_lo[%0d] op=%0d a=%h b=%h: got %h want %h", i, op, a, b, LO, m_lo); end
      end
   endtask

   initial begin
      test_reset();
      test_mult();
      test_div();
      test_back_to_back();
      test_cancel();
      test_start_while_busy();
      test_async_reset();
      test_madd();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
